victim_refill_controller: RTL

- Consumes the one-hot victim way chosen by the cache's replacement controller on a miss.
- Reads the victim's metadata and line, writes the line back to next-level memory if it is valid and dirty, then fetches the missing line and installs it in the victim way.
- Reports the install to the replacement controller as an access, so the LRU state is updated.
- Sits between the cache miss path, the tag/data arrays, the replacement controller and the next-level memory port.

---
 rtl/victim_refill_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/victim_refill_controller.sv
// rtl/victim_refill_controller.sv - victim writeback and line refill sequencer for one cache miss
//
// Purpose: takes one miss at a time, reads the victim way picked by the
// replacement controller, writes it back when valid and dirty, fetches the
// missing line from next-level memory and installs it in the victim way,
// then reports the install as an access so the LRU state is refreshed.
//
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   miss_*                - miss request (valid/ready handshake, index, tag)
//   selected_way          - one-hot victim way from the replacement controller
//   current_index/_access - index / accessed way reported to the replacement controller
//   access_valid          - access report pulse
//   meta_read_*           - tag/data array read request (1-cycle read latency)
//   meta_valid/dirty/tag/data - victim metadata and line returned by the arrays
//   wb_*                  - writeback request to next-level memory
//   mem_req_*             - fill request to next-level memory
//   mem_resp_*            - fill response from next-level memory
//   array_write_*         - install write into the arrays (valid=1, dirty=0)
//   refill_done           - completion pulse
module victim_refill_controller #(
    parameter int NUMBER_OF_WAYS = 8,
    parameter int INDEX_BITS     = 8,
    parameter int TAG_BITS       = 20,
    parameter int LINE_WIDTH     = 128
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 miss_valid,
    output logic                                 miss_ready,
    input  logic [INDEX_BITS-1:0]                miss_index,
    input  logic [TAG_BITS-1:0]                  miss_tag,
    input  logic [NUMBER_OF_WAYS-1:0]            selected_way,
    output logic [INDEX_BITS-1:0]                current_index,
    output logic [$clog2(NUMBER_OF_WAYS)-1:0]    current_access,
    output logic                                 access_valid,
    output logic                                 meta_read_en,
    output logic [INDEX_BITS-1:0]                meta_read_index,
    output logic [$clog2(NUMBER_OF_WAYS)-1:0]    meta_read_way,
    input  logic                                 meta_valid,
    input  logic                                 meta_dirty,
    input  logic [TAG_BITS-1:0]                  meta_tag,
    input  logic [LINE_WIDTH-1:0]                meta_data,
    output logic                                 wb_valid,
    input  logic                                 wb_ready,
    output logic [TAG_BITS+INDEX_BITS-1:0]       wb_address,
    output logic [LINE_WIDTH-1:0]                wb_data,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic [TAG_BITS+INDEX_BITS-1:0]       mem_req_address,
    input  logic                                 mem_resp_valid,
    input  logic [LINE_WIDTH-1:0]                mem_resp_data,
    output logic                                 array_write_en,
    output logic [INDEX_BITS-1:0]                array_write_index,
    output logic [$clog2(NUMBER_OF_WAYS)-1:0]    array_write_way,
    output logic [TAG_BITS-1:0]                  array_write_tag,
    output logic [LINE_WIDTH-1:0]                array_write_data,
    output logic                                 refill_done
);

    localparam int WAY_BITS = $clog2(NUMBER_OF_WAYS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_READ,
        ST_WRITEBACK,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_INSTALL
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   index_q, index_d;
    logic [TAG_BITS-1:0]     tag_q, tag_d;
    logic [WAY_BITS-1:0]     way_q, way_d;
    logic [TAG_BITS-1:0]     victim_tag_q, victim_tag_d;
    logic [LINE_WIDTH-1:0]   victim_data_q, victim_data_d;
    logic [LINE_WIDTH-1:0]   fill_data_q, fill_data_d;
    logic [WAY_BITS-1:0]     sel_way_enc;

    // Lowest set bit wins: scanning downwards lets the lowest index overwrite
    // any higher one. An all-zero vector falls through to way 0.
    always_comb begin
        sel_way_enc = '0;
        for (int i = NUMBER_OF_WAYS - 1; i >= 0; i--) begin
            if (selected_way[i]) begin
                sel_way_enc = WAY_BITS'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            tag_q         <= '0;
            way_q         <= '0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            fill_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            tag_q         <= tag_d;
            way_q         <= way_d;
            victim_tag_q  <= victim_tag_d;
            victim_data_q <= victim_data_d;
            fill_data_q   <= fill_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        tag_d          = tag_q;
        way_d          = way_q;
        victim_tag_d   = victim_tag_q;
        victim_data_d  = victim_data_q;
        fill_data_d    = fill_data_q;
        miss_ready     = 1'b0;
        meta_read_en   = 1'b0;
        wb_valid       = 1'b0;
        mem_req_valid  = 1'b0;
        array_write_en = 1'b0;
        access_valid   = 1'b0;
        refill_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    index_d = miss_index;
                    tag_d   = miss_tag;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                way_d        = sel_way_enc;
                meta_read_en = 1'b1;
                state_d      = ST_READ;
            end
            ST_READ: begin
                victim_tag_d  = meta_tag;
                victim_data_d = meta_data;
                state_d       = (meta_valid && meta_dirty) ? ST_WRITEBACK : ST_FILL_REQ;
            end
            ST_WRITEBACK: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_d = ST_FILL_REQ;
                end
            end
            ST_FILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    fill_data_d = mem_resp_data;
                    state_d     = ST_INSTALL;
                end
            end
            ST_INSTALL: begin
                array_write_en = 1'b1;
                access_valid   = 1'b1;
                refill_done    = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Passing miss_index through in IDLE lets the replacement controller
    // produce selected_way for the incoming miss; afterwards the latched index
    // keeps selected_way stable while the victim way is encoded.
    assign current_index     = (state_q == ST_IDLE) ? miss_index : index_q;
    assign current_access    = way_q;

    // The way register is loaded at the end of SELECT, so the read request
    // issued during SELECT uses the freshly encoded way directly.
    assign meta_read_index   = index_q;
    assign meta_read_way     = (state_q == ST_SELECT) ? sel_way_enc : way_q;

    assign wb_address        = {victim_tag_q, index_q};
    assign wb_data           = victim_data_q;
    assign mem_req_address   = {tag_q, index_q};

    assign array_write_index = index_q;
    assign array_write_way   = way_q;
    assign array_write_tag   = tag_q;
    assign array_write_data  = fill_data_q;

endmodule
